// File: rtl/unary_add_1_6_pkg.sv
// Shared constants for the serial unary adder/accumulator.
// Counter width default and read/write mode encoding.
package unary_add_1_6_pkg;

  localparam int WIDTH = 6;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

endpackage

// File: rtl/unary_add_1_6_if.sv
// Stream bus of the unary adder: A, B, en, read_or_write in;
// dout (unary stream) and C (sticky overflow) out.
interface unary_add_1_6_if;
  logic A;
  logic B;
  logic en;
  logic read_or_write;
  logic dout;
  logic C;

  modport master (
    output A, B, en, read_or_write,
    input  dout, C
  );

  modport slave (
    input  A, B, en, read_or_write,
    output dout, C
  );
endinterface

// File: rtl/unary_add_1_6_sat_counter.sv
// Saturating counter: adds 0..2 with sticky carry, or decrements to 0.
// Ports: clk, rst_n, add_en, inc, dec_en -> count, c, nonzero.
module unary_sat_counter
  import unary_add_1_6_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         add_en,
  input  logic [1:0]   inc,
  input  logic         dec_en,
  output logic [W-1:0] count,
  output logic         c,
  output logic         nonzero
);

  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W:0] sum;

  assign sum     = {1'b0, count} + {{(W-1){1'b0}}, inc};
  assign nonzero = |count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      c     <= 1'b0;
    end else if (add_en) begin
      if (sum > MAX) begin
        count <= {W{1'b1}};
        c     <= 1'b1;
      end else begin
        count <= sum[W-1:0];
      end
    end else if (dec_en && nonzero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/unary_add_1_6.sv
// Serial unary adder/accumulator top: mode decode and dout register.
// Ports: clk, rst_n, bus (slave: A, B, en, read_or_write, dout, C).
module unary_add_1_6
  import unary_add_1_6_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  unary_add_1_6_if.slave  bus
);

  logic         add_en;
  logic         dec_en;
  logic [1:0]   inc;
  logic [W-1:0] count;
  logic         c;
  logic         nonzero;

  assign inc = {1'b0, bus.A} + {1'b0, bus.B};

  always_comb begin
    add_en = 1'b0;
    dec_en = 1'b0;
    unique case (1'b1)
      !bus.en: ;
      bus.en && (bus.read_or_write == MODE_READ):
        dec_en = 1'b1;
      bus.en && (bus.read_or_write == MODE_WRITE):
        add_en = 1'b1;
      default: ;
    endcase
  end

  unary_sat_counter #(.W(W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_en  (add_en),
    .inc     (inc),
    .dec_en  (dec_en),
    .count   (count),
    .c       (c),
    .nonzero (nonzero)
  );

  assign bus.C = c;

  // dout mirrors the decrement: one 1 per unit drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout <= 1'b0;
    end else begin
      bus.dout <= dec_en && nonzero;
    end
  end

endmodule

// File: tb/tb_unary_add_1_6.sv
// Directed bench for unary_add_1_6: reset, accumulate, overflow,
// drain, partial drain/resume and asynchronous reset mid-drain.
module tb_unary_add_1_6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  unary_add_1_6_if bus ();

  unary_add_1_6 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic b,
                     input logic e, input logic rw);
    bus.A = a;
    bus.B = b;
    bus.en = e;
    bus.read_or_write = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, 1, 0);
      cyc(0, 0, 1, 0);
    end
  endtask

  task automatic drain(input string tag, input int n);
    int ones;
    int gap;
    int bad;
    ones = 0;
    gap = 0;
    bad = 0;
    for (int i = 0; i < n + 4; i++) begin
      cyc(0, 0, 1, 1);
      if (bus.dout) begin
        if (gap != 0) bad++;
        ones++;
      end else if (ones > 0) begin
        gap = 1;
      end
    end
    chk({tag, "_ones"}, ones, n);
    chk({tag, "_contig"}, bad, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 0);
    chk("rst_count", 32'(dut.u_cnt.count), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_c", 32'(bus.C), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.A = 0;
    bus.B = 0;
    bus.en = 0;
    bus.read_or_write = 0;
    #2;
    do_reset();

    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    chk("en0_count", 32'(dut.u_cnt.count), 0);
    chk("en0_dout", 32'(bus.dout), 0);

    pulses(10);
    chk("acc_count", 32'(dut.u_cnt.count), 20);
    chk("acc_c", 32'(bus.C), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    chk("acc_a_count", 32'(dut.u_cnt.count), 23);
    chk("acc_dout", 32'(bus.dout), 0);

    do_reset();
    pulses(30);
    cyc(1, 1, 1, 0);
    chk("ovf31_count", 32'(dut.u_cnt.count), 62);
    chk("ovf31_c", 32'(bus.C), 0);
    cyc(1, 1, 1, 0);
    chk("ovf32_count", 32'(dut.u_cnt.count), 63);
    chk("ovf32_c", 32'(bus.C), 1);
    cyc(1, 1, 1, 0);
    chk("ovf33_count", 32'(dut.u_cnt.count), 63);
    chk("ovf33_c", 32'(bus.C), 1);

    drain("drain63", 63);
    chk("drain_count", 32'(dut.u_cnt.count), 0);
    chk("drain_c", 32'(bus.C), 1);

    pulses(5);
    chk("part_count", 32'(dut.u_cnt.count), 10);
    begin
      int ones;
      ones = 0;
      for (int i = 0; i < 4; i++) begin
        cyc(0, 0, 1, 1);
        if (bus.dout) ones++;
      end
      chk("part_ones", ones, 4);
    end
    cyc(1, 1, 1, 0);
    chk("resume_count", 32'(dut.u_cnt.count), 8);
    chk("resume_dout", 32'(bus.dout), 0);
    drain("drain8", 8);

    // 61 + 2 saturates to 63 without overflow
    do_reset();
    pulses(30);
    cyc(1, 0, 1, 0);
    chk("sat61_pre", 32'(dut.u_cnt.count), 61);
    cyc(1, 1, 1, 0);
    chk("sat61_count", 32'(dut.u_cnt.count), 63);
    chk("sat61_c", 32'(bus.C), 0);
    cyc(1, 1, 1, 0);
    chk("sat63_c", 32'(bus.C), 1);

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    chk("mid_dout", 32'(bus.dout), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dout", 32'(bus.dout), 0);
    chk("async_count", 32'(dut.u_cnt.count), 0);
    chk("async_c", 32'(bus.C), 0);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 1);
    chk("post_dout", 32'(bus.dout), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_add_1_6.md
Name: unary_add_1_6

Overview:
- Serial unary adder and accumulator.
- Write mode: two unary bitstreams A and B are summed into a 6-bit saturating counter, adding A+B (0, 1 or 2) each enabled cycle.
- Read mode: the accumulated value is played back on dout as a unary stream of that many consecutive 1s.
- C flags that the accumulated sum exceeded the 6-bit range.
- Used as a leaf arithmetic block in unary/stochastic datapaths.

Parameters:
- WIDTH, 6, counter width. Maximum representable sum is 2^WIDTH-1 = 63.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  1  unary input stream A; one unit per cycle while high
- B  input  1  unary input stream B; one unit per cycle while high
- en  input  1  global enable. When low, counter and C hold; dout is driven 0.
- read_or_write  input  1  0 = write/accumulate, 1 = read/drain
- dout  output  1  registered unary output stream
- C  output  1  registered sticky overflow/carry flag

Behaviour:
- Internal register count [WIDTH-1:0].
- Reset (rst_n=0, asynchronous): count=0, dout=0, C=0. Takes effect immediately, including mid-accumulate or mid-drain.
- All other updates occur on the rising edge of clk only.
- en=0: count and C hold; dout<=0.
- Write mode (en=1, read_or_write=0):
  - sum = count + A + B, computed at WIDTH+1 bits.
  - If sum <= 63: count <= sum.
  - Otherwise: count <= 63 (saturate) and C <= 1.
  - dout <= 0 throughout write mode.
- C is sticky. It is cleared only by reset and is never cleared by reading.
- Read mode (en=1, read_or_write=1):
  - If count != 0: dout <= 1 and count <= count-1.
  - Otherwise: dout <= 0.
  - A and B are ignored.
- Latency:
  - dout rises one cycle after the first read-mode edge with count>0.
  - A stored value N produces exactly N consecutive 1s, followed by 0s.
- A and B are sampled every enabled write edge. Holding A=1 for k edges adds k.
- Mode switch:
  - Takes effect at the next edge, with no flush cycle.
  - Switching back to write mid-drain resumes accumulation from the remaining count.
- Simultaneous A=B=1 with count=62: sum=64 gives count=63 and C=1.
- Simultaneous A=B=1 with count=61 gives count=63, C unchanged.

Decomposition:
- Shared package: WIDTH default, mode encoding constants MODE_WRITE=0 and MODE_READ=1.
- Natural sub-module: unary_sat_counter. It holds count and C and provides saturating add of 0..2 and decrement-to-zero.
- The top level contains mode decode and the dout register.

Test Plan:
- Reset: hold rst_n=0 with random A/B/en -> count=0, dout=0, C=0. Deassert, then en=0 with A=B=1 for 5 cycles -> count stays 0.
- Accumulate: en=1, write mode, apply A=B=1 for one cycle then A=B=0, repeated 10 times -> count=20, C=0. Then A=1,B=0 for 3 cycles -> count=23.
- Overflow: 33 pulses of A=B=1 (one cycle each, alternating with idle cycles) -> count saturates at 63; C rises on the 32nd pulse (62+2=64) and stays 1.
- Drain: from count=63 switch read_or_write=1 -> dout=1 for exactly 63 consecutive cycles, then 0. count=0 and C still 1.
- Partial drain/resume: count=10; read 4 cycles (four 1s on dout); write A=B=1 for one cycle -> count=8. Read -> exactly eight 1s.
- Async reset mid-drain: assert rst_n between clock edges during read -> dout, count and C go to 0 immediately, without waiting for a clock edge.
